// File: rtl/sa_w_channel_pkg.sv
// Shared helpers for the slave-side W channel: master-ID width and packed WDATA slicing.
// Pure functions; no state, latency or backpressure of their own.
// Used by the order FIFO sizing and the head-master data mux.
package sa_w_channel_pkg;

    function automatic int id_width(input int mst_amt);
        return (mst_amt > 1) ? $clog2(mst_amt) : 1;
    endfunction

    // Low bit of master m's slice in a packed per-master bus of lane width w.
    function automatic int slice_lo(input int m, input int w);
        return m * w;
    endfunction

endpackage

// File: rtl/sa_w_channel_order_fifo.sv
// Order FIFO holding the master IDs of granted AWs, oldest first.
// Latency: a pushed entry becomes head on the next cycle (no bypass).
// Backpressure: push ignored while full; pop ignored while empty.
module sa_w_channel_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en != pop_en) begin
                count <= push_en ? count + 1'b1 : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry fully registered skid buffer (output register plus one skid register).
// Latency: 1 cycle from input acceptance to out_vld; 1 beat/cycle when out_rdy stays high.
// Backpressure: in_rdy is a registered not-full flag; absorbs one extra beat after out stalls.
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);
    logic             skid_vld;
    logic [WIDTH-1:0] skid_dat;
    logic             in_acc;

    assign in_rdy = ~skid_vld;
    assign in_acc = in_vld & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (!out_vld || out_rdy) begin
            // Output slot frees up: the skid entry is older than anything on the input.
            if (skid_vld) begin
                out_dat  <= skid_dat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_acc) begin
                out_dat <= in_dat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_acc) begin
            skid_dat <= in_dat;
            skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/sa_w_channel.sv
// Slave-side W arbitration: forwards one master's burst at a time in AW grant order.
// Latency: 1 cycle from beat acceptance to s_WVALID_o; new head usable the cycle after WLAST.
// Backpressure: dsp_WREADY_o only for the head master, gated by select and the skid not-full flag.
module sa_w_channel
    import sa_w_channel_pkg::*;
#(
    parameter int MST_AMT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MST_ID_W   = id_width(MST_AMT),
    parameter int ORD_DEPTH  = 4
) (
    input  logic                          ACLK_i,
    input  logic                          ARESET_i,
    input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
    input  logic [MST_AMT-1:0]            dsp_WLAST_i,
    input  logic [MST_AMT-1:0]            dsp_WVALID_i,
    input  logic [MST_AMT-1:0]            dsp_WDATA_sel_i,
    output logic [MST_AMT-1:0]            dsp_WREADY_o,
    input  logic                          AW_push_i,
    input  logic [MST_ID_W-1:0]           AW_mst_id_i,
    output logic                          AW_ready_o,
    output logic [DATA_WIDTH-1:0]         s_WDATA_o,
    output logic                          s_WLAST_o,
    output logic                          s_WVALID_o,
    input  logic                          s_WREADY_i
);
    logic [MST_ID_W-1:0]   head;
    logic                  ord_full;
    logic                  ord_empty;
    logic                  skid_rdy;
    logic                  beat_acc;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_dat;
    logic [DATA_WIDTH:0]   out_dat;

    sa_w_channel_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (ORD_DEPTH)
    ) u_order_fifo (
        .clk      (ACLK_i),
        .rst      (ARESET_i),
        .push     (AW_push_i),
        .push_dat (AW_mst_id_i),
        .pop      (beat_acc & beat_last),
        .head_dat (head),
        .full     (ord_full),
        .empty    (ord_empty)
    );

    assign AW_ready_o = ~ord_full;

    always_comb begin
        dsp_WREADY_o = '0;
        beat_dat     = '0;
        beat_last    = 1'b0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (!ord_empty && head == MST_ID_W'(m)) begin
                dsp_WREADY_o[m] = dsp_WDATA_sel_i[m] & skid_rdy;
                beat_dat        = dsp_WDATA_i[slice_lo(m, DATA_WIDTH) +: DATA_WIDTH];
                beat_last       = dsp_WLAST_i[m];
            end
        end
    end

    assign beat_acc = |(dsp_WREADY_o & dsp_WVALID_i);

    skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_skid (
        .clk     (ACLK_i),
        .rst     (ARESET_i),
        .in_vld  (beat_acc),
        .in_dat  ({beat_last, beat_dat}),
        .in_rdy  (skid_rdy),
        .out_vld (s_WVALID_o),
        .out_dat (out_dat),
        .out_rdy (s_WREADY_i)
    );

    assign s_WLAST_o = out_dat[DATA_WIDTH];
    assign s_WDATA_o = out_dat[DATA_WIDTH-1:0];

endmodule

// File: doc/sa_w_channel.md
Name: sa_W_channel

Overview:
- Slave-side W channel arbitration stage of the AXI4 interconnect; one instance per slave. It is the receiving end of every master's W dispatcher.
- Collects W beats from MST_AMT master dispatchers and forwards exactly one master's burst at a time to the slave.
- Burst order follows the AW grant order issued by this slave's AW arbiter, recorded in an internal order FIFO.
- Slave-facing output is registered through a 2-entry skid buffer.

Parameters:
- MST_AMT, 2, number of master dispatchers feeding this slave
- DATA_WIDTH, 32, WDATA width
- MST_ID_W, $clog2(MST_AMT), master index width
- ORD_DEPTH, 4, order FIFO entries (power of 2, ≥2)

Ports:
- ACLK_i  in  1  clock
- ARESET_i  in  1  reset; synchronous, active-high
- dsp_WDATA_i  in  DATA_WIDTH*MST_AMT  per-master WDATA; master m occupies slice [DATA_WIDTH*(m+1)-1 -: DATA_WIDTH]
- dsp_WLAST_i  in  MST_AMT  per-master WLAST
- dsp_WVALID_i  in  MST_AMT  per-master WVALID
- dsp_WDATA_sel_i  in  MST_AMT  bit m = master m's dispatcher currently targets this slave
- dsp_WREADY_o  out  MST_AMT  per-master WREADY
- AW_push_i  in  1  AW handshake to slave completed this cycle
- AW_mst_id_i  in  MST_ID_W  master granted on that AW
- AW_ready_o  out  1  order FIFO not full; AW arbiter must not grant while low
- s_WDATA_o  out  DATA_WIDTH  to slave
- s_WLAST_o  out  1  to slave
- s_WVALID_o  out  1  to slave
- s_WREADY_i  in  1  from slave

Behaviour:
- Reset (ARESET_i=1 at a clock edge): order FIFO empty; skid buffer empty; s_WVALID_o=0, s_WDATA_o=0, s_WLAST_o=0, dsp_WREADY_o=0, AW_ready_o=1.
- Reset mid-burst discards all FIFO entries and buffered beats with no partial output.
- Order FIFO:
  - Push when AW_push_i & AW_ready_o.
  - A push while full is ignored.
  - Pop on acceptance of a beat with WLAST.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers are ORD_DEPTH-wrap binary; full/empty come from a count register.
  - AW_ready_o = (count != ORD_DEPTH).
- Head master: h = FIFO head entry, valid only when count != 0. There is no bypass: an ID pushed into an empty FIFO becomes head on the next cycle.
- dsp_WREADY_o[m] = (count!=0) & (m==h) & dsp_WDATA_sel_i[m] & skid_bwd_ready. It is 0 for all other masters.
- Beat accepted from m = dsp_WREADY_o[m] & dsp_WVALID_i[m]. The accepted {WDATA, WLAST} is written into the skid buffer.
- After a WLAST pop, the new head is visible on the next cycle. There is therefore at least one bubble between bursts from different FIFO entries.
- Skid buffer:
  - 2 entries, registered outputs.
  - Latency from beat acceptance to s_WVALID_o is 1 cycle.
  - Sustains 1 beat/cycle while s_WREADY_i=1.
  - skid_bwd_ready is a registered "not full" flag.
  - s_WDATA_o/s_WLAST_o hold stable while s_WVALID_o=1 & s_WREADY_i=0.
- With s_WREADY_i=0, at most 2 beats are accepted after output stall begins. No beat is dropped or duplicated.
- WLAST is forwarded unmodified; beat count versus AWLEN is not checked here.
- If dsp_WDATA_sel_i[h]=0 while the head is valid, no beat is accepted; wait.

Decomposition:
- Shared interconnect package: MST_ID width function and the per-master slice macro/function for packed WDATA.
- Sub-module sa_W_order_fifo: ID FIFO with push/pop/count, width MST_ID_W, depth ORD_DEPTH.
- Output stage reuses the existing skid_buffer (SBUF_TYPE full-registered) with DATA_WIDTH+1 width.
- Head mux and WREADY gating stay in the top module.

Test Plan:
- Reset: hold ARESET_i 2 cycles with dsp_WVALID_i=2'b11 → s_WVALID_o=0, dsp_WREADY_o=2'b00, AW_ready_o=1.
- Single burst: AW_push_i with id=1, then master 1 drives 0xA0..0xA3 (WLAST on 0xA3), s_WREADY_i=1 → s_WDATA_o shows 0xA0..0xA3 on consecutive cycles, each 1 cycle after acceptance; s_WLAST_o only with 0xA3; FIFO empty afterwards.
- Ordering: push id 0 then id 1; master 1 valid first with 0xB0, master 0 sends 0xC0,0xC1(last) → dsp_WREADY_o[1]=0 until the cycle after 0xC1 is accepted; output order 0xC0,0xC1,0xB0.
- Backpressure: s_WREADY_i=0 for 3 cycles during a 6-beat burst → only 2 beats buffered; s_WDATA_o stable while stalled; all 6 beats delivered once and in order.
- Full/wrap: push ids 0,1,0,1 with no W traffic → AW_ready_o=0 and a 5th push is ignored. Complete a 1-beat burst → AW_ready_o=1 next cycle. Perform 8 further push/pop cycles → head IDs stay correct across pointer wrap.
- Reset mid-burst: assert ARESET_i after beat 2 of 4 → next cycle s_WVALID_o=0, FIFO empty, no residual beats emitted.
